// File: rtl/pix_stream_filter.sv
// Streaming grayscale pixel filter: bypass, invert, threshold or programmable 3x3 convolution
// over a raster-order frame on a valid/ready stream, with start/abort control and a done pulse.
module pix_stream_filter #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int COEF_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              VALID_IN,
    output logic              READY_OUT,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              VALID_OUT,
    input  logic              READY_IN,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        shift,
    input  logic [PIX_W-1:0]  threshold,
    input  logic              coef_we,
    input  logic [3:0]        coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int ACC_W = PIX_W + COEF_W + 5;

    localparam logic [COL_W-1:0]        COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]        ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]        COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0]        ROW_TWO  = ROW_W'(2);
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'({PIX_W{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_CONV   = 2'b10,
        MODE_THRESH = 2'b11
    } mode_t;

    state_t state;
    state_t state_nxt;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    mode_t            mode_q;
    logic [3:0]       shift_q;
    logic [PIX_W-1:0] thr_q;

    logic signed [COEF_W-1:0] kern [9];

    logic [PIX_W-1:0] lb_prev  [IMG_W];
    logic [PIX_W-1:0] lb_prev2 [IMG_W];
    logic [PIX_W-1:0] win      [9];
    logic [PIX_W-1:0] nwin     [9];

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;

    logic [PIX_W-1:0] conv_pix;
    logic [PIX_W-1:0] result;
    logic             out_en;

    logic accept;
    logic frame_start;
    logic frame_abort;
    logic last_pix;
    logic drain_exit;

    assign accept      = VALID_IN && READY_OUT;
    assign frame_start = (state == ST_IDLE) && start;
    assign frame_abort = (state != ST_IDLE) && abort;
    assign last_pix    = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign drain_exit  = (state == ST_DRAIN) && (!VALID_OUT || READY_IN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first keeps this combinational block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (last_pix) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort || drain_exit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        READY_OUT = (state == ST_RUN) && (!VALID_OUT || READY_IN);
    end

    // Frame configuration is frozen at start so mid-frame input changes cannot corrupt a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col        <= '0;
            row        <= '0;
            mode_q     <= MODE_BYPASS;
            shift_q    <= '0;
            thr_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= drain_exit && !abort;
            if (frame_start) begin
                mode_q  <= mode_t'(mode);
                shift_q <= shift;
                thr_q   <= threshold;
                col     <= '0;
                row     <= '0;
            end else if (frame_abort) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                kern[i] <= (i == 4) ? COEF_W'(1) : '0;
            end
        end else if ((state == ST_IDLE) && coef_we && (coef_idx <= 4'd8)) begin
            kern[coef_idx] <= coef_data;
        end
    end

    // NOTE: line buffers and window are pure storage, overwritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_prev2[col] <= lb_prev[col];
            lb_prev[col]  <= pixel_in;
            for (int i = 0; i < 9; i++) begin
                win[i] <= nwin[i];
            end
        end
    end

    // Window as it will look after this accept: rows r-2..r, columns c-2..c, row-major.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nwin[3*i]   = win[3*i+1];
            nwin[3*i+1] = win[3*i+2];
            nwin[3*i+2] = '0;
        end
        nwin[2] = lb_prev2[col];
        nwin[5] = lb_prev[col];
        nwin[8] = pixel_in;
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++) begin
            acc = acc + ACC_W'($signed({1'b0, nwin[i]})) * ACC_W'(kern[i]);
        end
        acc_sh = acc >>> shift_q;
        if (acc_sh[ACC_W-1]) begin
            conv_pix = '0;
        end else if (acc_sh > PIX_MAX) begin
            conv_pix = '1;
        end else begin
            conv_pix = acc_sh[PIX_W-1:0];
        end
    end

    always_comb begin
        result = pixel_in;
        out_en = 1'b1;
        case (mode_q)
            MODE_BYPASS: result = pixel_in;
            MODE_INVERT: result = ~pixel_in;
            MODE_THRESH: result = (pixel_in >= thr_q) ? '1 : '0;
            MODE_CONV: begin
                result = conv_pix;
                out_en = (row >= ROW_TWO) && (col >= COL_TWO);
            end
            default: result = pixel_in;
        endcase
    end

    // A new output always wins over a consume, so back-to-back transfers keep VALID_OUT high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pixel_out <= '0;
            VALID_OUT <= 1'b0;
        end else if (frame_abort) begin
            VALID_OUT <= 1'b0;
        end else if (accept && out_en) begin
            pixel_out <= result;
            VALID_OUT <= 1'b1;
        end else if (READY_IN) begin
            VALID_OUT <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pix_stream_filter.sv
// Randomized self-checking bench for pix_stream_filter against an array-based frame model.
module tb_pix_stream_filter;

    localparam int PIX_W  = 8;
    localparam int W      = 32;
    localparam int H      = 32;
    localparam int COEF_W = 5;

    logic              clk;
    logic              rstn;
    logic [PIX_W-1:0]  pixel_in;
    logic              VALID_IN;
    logic              READY_OUT;
    logic [PIX_W-1:0]  pixel_out;
    logic              VALID_OUT;
    logic              READY_IN;
    logic [1:0]        mode;
    logic              start;
    logic              abort;
    logic [3:0]        shift;
    logic [PIX_W-1:0]  threshold;
    logic              coef_we;
    logic [3:0]        coef_idx;
    logic [COEF_W-1:0] coef_data;
    logic              busy;
    logic              frame_done;

    int total;
    int bad;

    logic [7:0] img [0:H-1][0:W-1];
    int         kmod [9];
    logic [7:0] exp_q [$];

    pix_stream_filter #(
        .PIX_W (PIX_W),
        .IMG_W (W),
        .IMG_H (H),
        .COEF_W(COEF_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pixel_in  (pixel_in),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .pixel_out (pixel_out),
        .VALID_OUT (VALID_OUT),
        .READY_IN  (READY_IN),
        .mode      (mode),
        .start     (start),
        .abort     (abort),
        .shift     (shift),
        .threshold (threshold),
        .coef_we   (coef_we),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void kernel_identity();
        for (int i = 0; i < 9; i++) kmod[i] = (i == 4) ? 1 : 0;
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(r * 32 + c);
    endfunction

    function automatic void fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(v);
    endfunction

    function automatic void fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
    endfunction

    // Golden outputs in output order: per pixel for point modes, interior centres for conv.
    function automatic void build_expected(input logic [1:0] md, input int sh, input int th);
        int s;
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (md)
                    2'b00: exp_q.push_back(img[r][c]);
                    2'b01: exp_q.push_back(~img[r][c]);
                    2'b11: exp_q.push_back((int'(img[r][c]) >= th) ? 8'hFF : 8'h00);
                    default: begin
                        if (r >= 2 && c >= 2) begin
                            s = 0;
                            for (int i = 0; i < 3; i++)
                                for (int j = 0; j < 3; j++)
                                    s += kmod[i*3+j] * int'(img[r-2+i][c-2+j]);
                            s = s >>> sh;
                            if (s < 0) s = 0;
                            if (s > 255) s = 255;
                            exp_q.push_back(8'(s));
                        end
                    end
                endcase
            end
        end
    endfunction

    task automatic write_coef(input int idx, input int val);
        @(posedge clk); #1;
        coef_we   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = COEF_W'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
        if (idx <= 8) kmod[idx] = val;
    endtask

    // stop_kind: 0 = abort when stop_at pixels accepted, 1 = async reset at that point.
    task automatic run_frame(input string name, input logic [1:0] md, input int sh, input int th,
                             input int rdy_pct, input int vld_pct, input int stop_at,
                             input int stop_kind, input bit poke);
        int         sent;
        int         n_out;
        int         n_exp;
        int         cyc;
        int         r;
        int         c;
        bit         finished;
        bit         hold_v;
        bit         exp_done;
        bit         exp_vnext;
        logic [7:0] hold;
        logic [7:0] e;

        build_expected(md, sh, th);
        n_exp = exp_q.size();

        @(posedge clk); #1;
        start     = 1'b1;
        mode      = md;
        shift     = 4'(sh);
        threshold = 8'(th);
        @(posedge clk); #1;
        start     = 1'b0;
        mode      = 2'($urandom);
        shift     = 4'($urandom);
        threshold = 8'($urandom);
        check({name, "_busy_start"}, busy, 1);

        sent = 0; n_out = 0; cyc = 0;
        finished = 0; hold_v = 0; exp_done = 0; exp_vnext = 0; hold = '0;

        while (cyc < 20000) begin
            cyc++;
            if (stop_at >= 0 && sent == stop_at) begin
                VALID_IN = 1'b0;
                READY_IN = 1'b0;
                coef_we  = 1'b0;
                if (stop_kind == 0) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    check({name, "_abort_valid"}, VALID_OUT, 0);
                    check({name, "_abort_busy"}, busy, 0);
                    check({name, "_abort_ready"}, READY_OUT, 0);
                    check({name, "_abort_done"}, frame_done, 0);
                    @(negedge clk);
                    check({name, "_abort_done2"}, frame_done, 0);
                end else begin
                    #1 rstn = 1'b0;
                    #1;
                    check({name, "_rst_valid"}, VALID_OUT, 0);
                    check({name, "_rst_pix"}, pixel_out, 0);
                    check({name, "_rst_busy"}, busy, 0);
                    check({name, "_rst_ready"}, READY_OUT, 0);
                    check({name, "_rst_done"}, frame_done, 0);
                    repeat (2) @(posedge clk);
                    #1 rstn = 1'b1;
                    kernel_identity();
                end
                return;
            end

            VALID_IN = (sent < W * H) && ($urandom_range(99) < vld_pct);
            pixel_in = (sent < W * H) ? img[sent / W][sent % W] : 8'($urandom);
            READY_IN = ($urandom_range(99) < rdy_pct);
            if (poke && sent == 100) begin
                coef_we   = 1'b1;
                coef_idx  = 4'($urandom_range(8));
                coef_data = COEF_W'($urandom);
            end else begin
                coef_we = 1'b0;
            end

            @(negedge clk);
            check({name, "_done"}, frame_done, exp_done);
            if (exp_vnext) check({name, "_latency"}, VALID_OUT, 1);
            if (hold_v) check({name, "_stable"}, {VALID_OUT, pixel_out}, {1'b1, hold});
            if (exp_done) begin
                check({name, "_busy_end"}, busy, 0);
                finished = 1;
                break;
            end

            hold_v = VALID_OUT && !READY_IN;
            hold   = pixel_out;
            if (VALID_OUT && READY_IN) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_out"}, pixel_out, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_px"}, pixel_out, e);
                    n_out++;
                    exp_done = (exp_q.size() == 0);
                end
            end
            exp_vnext = 0;
            if (VALID_IN && READY_OUT) begin
                r = sent / W;
                c = sent % W;
                exp_vnext = (md != 2'b10) || (r >= 2 && c >= 2);
                sent++;
            end

            @(posedge clk); #1;
        end

        check({name, "_finished"}, finished, 1);
        @(posedge clk); #1;
        VALID_IN = 1'b0;
        READY_IN = 1'b1;
        coef_we  = 1'b0;
        @(negedge clk);
        check({name, "_done_pulse"}, frame_done, 0);
        check({name, "_idle_valid"}, VALID_OUT, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_count"}, n_out, n_exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int sh;
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        pixel_in  = '0;
        VALID_IN  = 1'b0;
        READY_IN  = 1'b0;
        mode      = 2'b00;
        start     = 1'b0;
        abort     = 1'b0;
        shift     = '0;
        threshold = '0;
        coef_we   = 1'b0;
        coef_idx  = '0;
        coef_data = '0;
        kernel_identity();

        #3;
        check("reset_pix", pixel_out, 0);
        check("reset_valid", VALID_OUT, 0);
        check("reset_ready", READY_OUT, 0);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        READY_IN = 1'b1;
        @(negedge clk);
        check("idle_ready", READY_OUT, 0);
        @(posedge clk); #1;

        fill_ramp();
        run_frame("bypass", 2'b00, 0, 0, 100, 100, -1, 0, 0);

        fill_rand();
        img[0][0] = 8'h7F;
        img[0][1] = 8'h80;
        run_frame("invert", 2'b01, 0, 0, 100, 100, -1, 0, 0);
        run_frame("thresh", 2'b11, 0, 128, 60, 80, -1, 0, 0);

        fill_ramp();
        run_frame("conv_ident", 2'b10, 0, 0, 100, 100, -1, 0, 0);

        for (int i = 0; i < 9; i++) write_coef(i, 1);
        fill_const(80);
        run_frame("conv_box", 2'b10, 3, 0, 100, 100, -1, 0, 0);

        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 8 : -1);
        fill_const(0);
        img[5][5]   = 8'hFF;
        img[20][27] = 8'hFF;
        img[0][0]   = 8'hFF;
        img[31][31] = 8'hFF;
        run_frame("conv_lap", 2'b10, 0, 0, 100, 100, -1, 0, 0);

        for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(14)) - 7);
        write_coef(12, 3);
        sh = $urandom_range(4);
        fill_rand();
        run_frame("conv_rand", 2'b10, sh, 0, 50, 70, -1, 0, 1);
        run_frame("conv_abort", 2'b10, sh, 0, 50, 80, 500, 0, 0);
        fill_rand();
        run_frame("conv_after_abort", 2'b10, sh, 0, 50, 90, -1, 0, 0);

        run_frame("thresh_reset", 2'b11, 0, 100, 70, 90, 300, 1, 0);
        fill_rand();
        run_frame("conv_after_reset", 2'b10, 0, 0, 50, 80, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
